// File: rtl/symbol_framer_pkg.sv
// Shared definitions for the symbol framer: modulation codes, bits-per-symbol
// lookup and framer state encodings.
package symbol_framer_pkg;

    localparam logic [1:0] MOD_QPSK   = 2'b00;
    localparam logic [1:0] MOD_QAM16  = 2'b01;
    localparam logic [1:0] MOD_QAM64  = 2'b10;
    localparam logic [1:0] MOD_QAM256 = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] bits_per_sym(input logic [1:0] m);
        case (m)
            MOD_QPSK:   return 4'd2;
            MOD_QAM16:  return 4'd4;
            MOD_QAM64:  return 4'd6;
            MOD_QAM256: return 4'd8;
            default:    return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/symbol_framer_fifo.sv
// Synchronous FIFO with a combinational head; storage is not reset, only the
// pointers and occupancy count.
module sym_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam logic [AW-1:0] ONE_P = 1;
    localparam logic [AW:0]   ONE_C = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE_P;
            if (do_pop)  rd_ptr <= rd_ptr + ONE_P;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/symbol_framer.sv
// Deserializes a coded bit stream into M-ary symbols, buffers them and hands
// them to the sorter in fixed-length frames gated by start/done.
module symbol_framer
    import symbol_framer_pkg::*;
#(
    parameter int FRAME_SYMS = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int SYM_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       M,
    input  logic             bitIn,
    input  logic             bitValid,
    output logic             bitReady,
    output logic [SYM_W-1:0] symOut,
    output logic             symValid,
    input  logic             symReady,
    output logic             frameLast,
    output logic             start,
    input  logic             done
);
    localparam int SCW = $clog2(FRAME_SYMS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [SCW-1:0] ONE_S = 1;

    state_t           state, state_nxt;
    logic [1:0]       m_lat, m_eff;
    logic [3:0]       bps;
    logic [SYM_W-1:0] shift, shift_nxt, sym_mask;
    logic [2:0]       bit_cnt;
    logic [SCW-1:0]   sym_cnt;
    logic             done_seen;
    logic             accept, sym_done, frame_end, pop;
    logic [SYM_W:0]   fifo_din, fifo_head;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;

    // In IDLE the modulation is latched on this very bit, so use M directly.
    assign m_eff     = (state == IDLE) ? M : m_lat;
    assign bps       = bits_per_sym(m_eff);
    assign sym_mask  = SYM_W'((32'd1 << bps) - 32'd1);
    assign shift_nxt = {shift[SYM_W-2:0], bitIn};

    assign bitReady  = (state != WAIT_DONE) && !fifo_full;
    assign accept    = bitValid && bitReady;
    assign sym_done  = accept && ({1'b0, bit_cnt} == bps - 4'd1);
    assign frame_end = (sym_cnt == SCW'(FRAME_SYMS - 1));
    assign fifo_din  = {frame_end, shift_nxt & sym_mask};

    assign symValid  = (fifo_count != '0);
    assign pop       = symValid && symReady;
    assign symOut    = symValid ? fifo_head[SYM_W-1:0] : '0;
    assign frameLast = symValid && fifo_head[SYM_W];

    sym_fifo #(.WIDTH(SYM_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sym_done),
        .pop   (pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = COLLECT;
            COLLECT:   if (sym_done && frame_end) state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_seen && fifo_empty) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_lat     <= MOD_QPSK;
            shift     <= '0;
            bit_cnt   <= '0;
            sym_cnt   <= '0;
            done_seen <= 1'b0;
            start     <= 1'b0;
        end else begin
            if (accept && state == IDLE) m_lat <= M;
            if (sym_done) begin
                shift   <= '0;
                bit_cnt <= '0;
                sym_cnt <= frame_end ? '0 : sym_cnt + ONE_S;
            end else if (accept) begin
                shift   <= shift_nxt;
                bit_cnt <= bit_cnt + 3'd1;
            end
            // The first push of a frame and the pop of its last entry never coincide.
            if (sym_done && sym_cnt == '0)  start <= 1'b1;
            else if (pop && fifo_head[SYM_W]) start <= 1'b0;
            if (state == WAIT_DONE) begin
                if (done_seen && fifo_empty) done_seen <= 1'b0;
                else if (done)               done_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_symbol_framer.sv
// Directed bench for symbol_framer: a 4-symbol-frame instance and a default
// 16-symbol-frame instance share stimulus; sel picks which one is observed.
module tb_symbol_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] M = 2'b00;
    logic       bitIn = 1'b0, bitValid = 1'b0, symReady = 1'b0, done = 1'b0;
    logic       br4, sv4, fl4, st4, br16, sv16, fl16, st16;
    logic [7:0] so4, so16;
    logic       sel = 1'b0;
    logic [11:0] stat;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    symbol_framer #(.FRAME_SYMS(4), .FIFO_DEPTH(8), .SYM_W(8)) dut4 (
        .clk(clk), .rst(rst), .M(M), .bitIn(bitIn), .bitValid(bitValid),
        .bitReady(br4), .symOut(so4), .symValid(sv4), .symReady(symReady),
        .frameLast(fl4), .start(st4), .done(done)
    );

    symbol_framer #(.FRAME_SYMS(16), .FIFO_DEPTH(8), .SYM_W(8)) dut16 (
        .clk(clk), .rst(rst), .M(M), .bitIn(bitIn), .bitValid(bitValid),
        .bitReady(br16), .symOut(so16), .symValid(sv16), .symReady(symReady),
        .frameLast(fl16), .start(st16), .done(done)
    );

    // {symValid, frameLast, start, bitReady, symOut}
    assign stat = sel ? {sv16, fl16, st16, br16, so16} : {sv4, fl4, st4, br4, so4};

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bitValid = 1'b0; done = 1'b0; symReady = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int t = 0;
        @(negedge clk);
        while (!stat[8] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL bitReady_timeout got %b exp 1", stat[8]);
        end
        bitIn = b; bitValid = 1'b1;
        @(posedge clk); #1 bitValid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sv4, fl4, st4, br4, so4} !== 12'b0001_0000_0000) begin
            errors++; $display("FAIL reset_f4 got %h exp %h", {sv4, fl4, st4, br4, so4}, 12'h100);
        end
        checks++;
        if ({sv16, fl16, st16, br16, so16} !== 12'b0001_0000_0000) begin
            errors++; $display("FAIL reset_f16 got %h exp %h", {sv16, fl16, st16, br16, so16}, 12'h100);
        end
    endtask

    task automatic test_qpsk_frame();
        logic [7:0]  syms [4] = '{8'h02, 8'h03, 8'h00, 8'h01};
        logic [11:0] exp;
        sel = 1'b0; M = 2'b00;
        do_reset();
        symReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_bit(syms[k][1]);
            send_bit(syms[k][0]);
            exp = {1'b1, (k == 3), 1'b1, (k != 3), syms[k]};
            checks++;
            if (stat !== exp) begin
                errors++; $display("FAIL qpsk_sym%0d got %h exp %h", k, stat, exp);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (stat !== 12'h000) begin
            errors++; $display("FAIL qpsk_start_fall got %h exp %h", stat, 12'h000);
        end
        pulse_done();
        checks++;
        if (stat[8] !== 1'b0) begin
            errors++; $display("FAIL qpsk_wait_done got %b exp 0", stat[8]);
        end
        @(posedge clk); #1;
        checks++;
        if (stat !== 12'h100) begin
            errors++; $display("FAIL qpsk_back_idle got %h exp %h", stat, 12'h100);
        end
    endtask

    task automatic test_qam();
        logic [1:0]  qm [3] = '{2'b01, 2'b10, 2'b11};
        int          qn [3] = '{4, 6, 8};
        logic [7:0]  qv [3] = '{8'h0B, 8'h35, 8'hF0};
        sel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            M = qm[k];
            do_reset();
            symReady = 1'b1;
            for (int i = 0; i < qn[k] - 1; i++) send_bit(qv[k][qn[k]-1-i]);
            checks++;
            if (stat[11] !== 1'b0) begin
                errors++; $display("FAIL qam%0d_early got %b exp 0", qn[k], stat[11]);
            end
            send_bit(qv[k][0]);
            checks++;
            if (stat !== {4'b1011, qv[k]}) begin
                errors++; $display("FAIL qam%0d_sym got %h exp %h", qn[k], stat, {4'b1011, qv[k]});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] s;
        sel = 1'b1; M = 2'b00;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s = 2'(i % 4);
            send_bit(s[1]);
            send_bit(s[0]);
        end
        checks++;
        if (stat !== 12'hA00) begin
            errors++; $display("FAIL bp_full got %h exp %h", stat, 12'hA00);
        end
        @(negedge clk);
        symReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({stat[11], stat[7:0]} !== {1'b1, 8'(i % 4)}) begin
                errors++; $display("FAIL bp_drain%0d got %h exp %h", i, {stat[11], stat[7:0]}, {1'b1, 8'(i % 4)});
            end
            @(negedge clk);
        end
        symReady = 1'b0;
        checks++;
        if (stat !== 12'h300) begin
            errors++; $display("FAIL bp_empty got %h exp %h", stat, 12'h300);
        end
    endtask

    task automatic test_m_change();
        sel = 1'b0; M = 2'b00;
        do_reset();
        symReady = 1'b1;
        send_bit(1'b1); send_bit(1'b1);
        checks++;
        if (stat !== 12'hB03) begin
            errors++; $display("FAIL mchg_sym0 got %h exp %h", stat, 12'hB03);
        end
        M = 2'b11;
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (stat !== 12'hB02) begin
            errors++; $display("FAIL mchg_sym1 got %h exp %h", stat, 12'hB02);
        end
        send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1);
        checks++;
        if (stat !== 12'hE03) begin
            errors++; $display("FAIL mchg_last got %h exp %h", stat, 12'hE03);
        end
        @(posedge clk); #1;
        pulse_done();
        @(posedge clk); #1;
        send_bit(1'b1); send_bit(1'b0);
        checks++;
        if (stat[11] !== 1'b0) begin
            errors++; $display("FAIL mchg_wide_early got %b exp 0", stat[11]);
        end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (stat !== 12'hBA5) begin
            errors++; $display("FAIL mchg_wide_sym got %h exp %h", stat, 12'hBA5);
        end
    endtask

    task automatic test_done_early();
        logic [7:0] rest [3] = '{8'h03, 8'h00, 8'h01};
        logic [1:0] bits [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
        sel = 1'b0; M = 2'b00;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_bit(bits[k][1]);
            send_bit(bits[k][0]);
        end
        checks++;
        if (stat !== 12'hA02) begin
            errors++; $display("FAIL early_full_frame got %h exp %h", stat, 12'hA02);
        end
        @(negedge clk); symReady = 1'b1;
        @(posedge clk); #1 symReady = 1'b0;
        pulse_done();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (stat !== 12'hA03) begin
            errors++; $display("FAIL early_hold got %h exp %h", stat, 12'hA03);
        end
        @(negedge clk);
        symReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({stat[11:10], stat[7:0]} !== {1'b1, (i == 2), rest[i]}) begin
                errors++; $display("FAIL early_drain%0d got %h exp %h", i, {stat[11:10], stat[7:0]}, {1'b1, (i == 2), rest[i]});
            end
            @(negedge clk);
        end
        symReady = 1'b0;
        checks++;
        if (stat !== 12'h000) begin
            errors++; $display("FAIL early_still_wait got %h exp %h", stat, 12'h000);
        end
        @(posedge clk); #1;
        checks++;
        if (stat !== 12'h100) begin
            errors++; $display("FAIL early_idle got %h exp %h", stat, 12'h100);
        end
        send_bit(1'b1); send_bit(1'b1);
        checks++;
        if (stat !== 12'hB03) begin
            errors++; $display("FAIL early_next_frame got %h exp %h", stat, 12'hB03);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0; M = 2'b00;
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        checks++;
        if (stat !== 12'hB02) begin
            errors++; $display("FAIL rmid_before got %h exp %h", stat, 12'hB02);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++;
        if (stat !== 12'h100) begin
            errors++; $display("FAIL rmid_after got %h exp %h", stat, 12'h100);
        end
        send_bit(1'b1);
        checks++;
        if (stat[11] !== 1'b0) begin
            errors++; $display("FAIL rmid_partial got %b exp 0", stat[11]);
        end
        send_bit(1'b0);
        checks++;
        if (stat !== 12'hB02) begin
            errors++; $display("FAIL rmid_fresh got %h exp %h", stat, 12'hB02);
        end
    endtask

    initial begin
        test_reset();
        test_qpsk_frame();
        test_qam();
        test_backpressure();
        test_m_change();
        test_done_early();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/symbol_framer.md
Name: symbol_framer

Overview:
- Upstream feeder for the sorter control/datapath.
- Deserializes a coded bit stream into M-ary symbol indices: QPSK 2 bits, QAM16 4, QAM64 6, QAM256 8.
- Buffers the symbols in a small FIFO and delivers them in fixed-length frames.
- Drives the sorter's `start` level and waits for the sorter's `done` before opening the next frame.

Parameters:
- FRAME_SYMS, 16, symbols per frame (≥2).
- FIFO_DEPTH, 8, symbol FIFO entries (power of 2).
- SYM_W, 8, symbol output width (max bits per symbol).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- M  in  2  modulation: 00 QPSK, 01 QAM16, 10 QAM64, 11 QAM256.
- bitIn  in  1  serial coded bit, MSB of symbol first.
- bitValid  in  1  bitIn qualifier.
- bitReady  out  1  block can accept a bit this cycle.
- symOut  out  SYM_W  FIFO head symbol, zero-extended.
- symValid  out  1  symOut valid (FIFO not empty).
- symReady  in  1  consumer takes symOut when symValid && symReady.
- frameLast  out  1  head symbol is the last of its frame.
- start  out  1  level to sorter, high for the frame's duration.
- done  in  1  sorter completion pulse.

Behaviour:
- Reset (clk edge with rst=1): state IDLE, FIFO empty, counters 0. Outputs: bitReady=1, symValid=0, symOut=0, frameLast=0, start=0. Reset mid-frame discards all partial and buffered data.
- BPS derived from the latched modulation mLat: 00→2, 01→4, 10→6, 11→8.
- States: IDLE, COLLECT, WAIT_DONE.
- IDLE:
  - On the first accepted bit, latch mLat <= M and go to COLLECT.
  - That first bit counts toward the first symbol.
  - M changes after latching are ignored until the next IDLE.
- bitReady = (state != WAIT_DONE) && !fifoFull. A bit is accepted on bitValid && bitReady.
- On acceptance:
  - shift <= {shift[SYM_W-2:0], bitIn}; bitCnt++.
  - When bitCnt == BPS-1, push the low BPS bits of the updated shift (zero-extended) into the FIFO, clear bitCnt and shift, and increment symCnt.
  - Each FIFO entry carries a last-tag set when symCnt == FRAME_SYMS-1.
- Pushing the last symbol: symCnt <= 0, state -> WAIT_DONE.
- FIFO:
  - SYM_W+1 bits wide (symbol + tag).
  - symValid = count != 0; symOut and frameLast reflect the head.
  - Latency: the symbol is visible on symOut the cycle after its last bit is accepted.
  - Simultaneous push and pop leaves count unchanged.
  - Push while full cannot occur (bitReady gated).
  - Pop while empty is ignored.
- start:
  - Set to 1 on the cycle the first symbol of a frame is pushed.
  - Cleared to 0 on the cycle after the tagged-last symbol is popped.
  - Never high in IDLE with an empty FIFO.
- WAIT_DONE:
  - A done pulse sets doneSeen; done seen in any other state is ignored.
  - Go to IDLE when doneSeen && FIFO empty, clearing doneSeen.
  - If done and the final pop coincide, the transition happens the next cycle.
  - bitReady stays 0 for the whole of WAIT_DONE.
- Width rules: bitCnt is 3 bits and symCnt is ceil(log2(FRAME_SYMS)) bits; neither wraps outside the rules above.

Decomposition:
- Shared package holds:
  - modulation codes: QPSK=2'b00, QAM16=2'b01, QAM64=2'b10, QAM256=2'b11;
  - a bits-per-symbol function;
  - state encodings IDLE/COLLECT/WAIT_DONE.
- One sub-module: sym_fifo, a synchronous FIFO parameterized on width and depth, with push, pop, head, full, empty and count.
- Framer FSM and deserializer stay in symbol_framer.

Test Plan:
- QPSK, FRAME_SYMS=4, symReady=1, bits 1,0,1,1,0,0,0,1 → symOut sequence 0x02,0x03,0x00,0x01. frameLast is set on 0x01. start rises with the first push and falls the cycle after the 0x01 pop. bitReady=0 until done.
- QAM16 bits 1,0,1,1 → 0x0B. QAM64 bits 1,1,0,1,0,1 → 0x35. QAM256 bits 1,1,1,1,0,0,0,0 → 0xF0. Each appears one cycle after its last bit.
- Backpressure: symReady=0, QPSK, 16 bits supplied → FIFO holds 8, bitReady drops after the 8th push, no symbol lost. Releasing symReady drains 8 in order.
- M change: M switched from 00 to 11 mid-frame → remaining symbols still 2-bit. The next frame after done uses 8-bit symbols.
- done before drain: done pulses while 3 symbols remain → state stays WAIT_DONE until the FIFO is empty, then IDLE. A second frame then starts normally.
- Reset mid-frame: rst for 1 cycle after 5 QPSK bits → symValid=0, start=0, bitReady=1. The next 2 bits form a fresh symbol.
